// File: rtl/logic_accum_pipe_if.sv
// Handshake bundle for logic_accum_pipe: input beat channel, result channel and beat counter.
// The DUT connects through the slave modport; a driver or bench uses master.
interface logic_accum_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic [15:0]      count;

    modport master (
        output in_valid, in_data, mode, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, out_parity, count
    );

    modport slave (
        input  in_valid, in_data, mode, acc_clr, out_ready,
        output in_ready, out_valid, out_data, out_parity, count
    );
endinterface

// File: rtl/logic_accum_pipe.sv
// Sample register A and XOR accumulator B combined by a selectable bitwise op; results leave
// through a DEPTH-stage elastic valid/ready pipeline.
module logic_accum_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    logic_accum_pipe_if.slave bus
);
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [15:0]      r_count;
    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    logic             w_accept;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_result;
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_src_valid;
    logic [WIDTH-1:0] w_src_data [DEPTH];

    // A stage may load iff some stage at or after it is empty, or the tail drains this cycle.
    always_comb begin : load_calc
        logic v_any;
        v_any = bus.out_ready;
        w_load = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            v_any = v_any | ~r_valid[i];
            w_load[i] = v_any;
        end
    end

    assign bus.in_ready = w_load[0];
    assign w_accept     = bus.in_valid & w_load[0];

    // A simultaneous clear makes the old A and B count as zero for this beat.
    assign w_a_next = bus.in_data;
    assign w_b_next = bus.acc_clr ? '0 : (r_a ^ r_b);

    always_comb begin
        w_result = '0;
        unique case (bus.mode)
            2'b00: w_result = w_a_next & w_b_next;
            2'b01: w_result = w_a_next | w_b_next;
            2'b10: w_result = w_a_next ^ w_b_next;
            2'b11: w_result = ~(w_a_next ^ w_b_next);
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_a <= w_a_next;
            r_b <= w_b_next;
            if (bus.acc_clr) begin
                r_count <= 16'd1;
            end else if (r_count != 16'hFFFF) begin
                r_count <= r_count + 16'd1;
            end
        end else if (bus.acc_clr) begin
            r_a     <= '0;
            r_b     <= '0;
            r_count <= '0;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_src
        if (g == 0) begin : g_head
            assign w_src_valid[g] = w_accept;
            assign w_src_data[g]  = w_result;
        end else begin : g_body
            assign w_src_valid[g] = r_valid[g-1];
            assign w_src_data[g]  = r_data[g-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= w_src_valid[i];
                    if (w_src_valid[i]) begin
                        r_data[i] <= w_src_data[i];
                    end
                end
            end
        end
    end

    assign bus.out_valid  = r_valid[DEPTH-1];
    assign bus.out_data   = r_data[DEPTH-1];
    assign bus.out_parity = ^r_data[DEPTH-1];
    assign bus.count      = r_count;
endmodule

// File: tb/tb_logic_accum_pipe.sv
// Bench for logic_accum_pipe: behavioural result queue plus per-cycle compare, directed scenarios
// with literal expectations, a randomized phase and a counter saturation stream.
module tb_logic_accum_pipe;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic_accum_pipe_if #(.WIDTH(WIDTH)) bus ();

    logic_accum_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [15:0]      m_count;
    logic [WIDTH-1:0] exp_q[$];
    int               acc_cyc_q[$];
    logic [WIDTH-1:0] got_q[$];
    int               lat_q[$];
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0] m);
        case (m)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // Reference model: evaluated mid-cycle while inputs are stable, effects apply at next edge.
    always @(negedge clk) begin : mon
        logic             exp_ready;
        logic [WIDTH-1:0] a_n;
        logic [WIDTH-1:0] b_n;
        cyc++;
        if (rst) begin
            m_a = '0;
            m_b = '0;
            m_count = '0;
            exp_q.delete();
            acc_cyc_q.delete();
            prev_stall = 1'b0;
        end else begin
            exp_ready = (exp_q.size() < DEPTH) || bus.out_ready;
            check("in_ready", bus.in_ready, exp_ready);
            check("count", bus.count, m_count);
            if (exp_q.size() == 0) check("out_valid_idle", bus.out_valid, 1'b0);
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1'b1);
                check("stall_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                check("out_data", bus.out_data, exp_q[0]);
                check("out_parity", bus.out_parity, ^exp_q[0]);
                got_q.push_back(bus.out_data);
                lat_q.push_back(cyc - acc_cyc_q[0]);
                void'(exp_q.pop_front());
                void'(acc_cyc_q.pop_front());
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.in_valid && exp_ready) begin
                b_n = bus.acc_clr ? '0 : (m_a ^ m_b);
                a_n = bus.in_data;
                exp_q.push_back(combine(a_n, b_n, bus.mode));
                acc_cyc_q.push_back(cyc);
                m_a = a_n;
                m_b = b_n;
                if (bus.acc_clr) m_count = 16'd1;
                else if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end else if (bus.acc_clr) begin
                m_a = '0;
                m_b = '0;
                m_count = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] m, input logic clr);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = m;
        bus.acc_clr  = clr;
        step();
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_out_parity", bus.out_parity, 1'b0);
        check("rst_count", bus.count, 16'd0);
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1'b1);
        got_q.delete();
        lat_q.delete();
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mode     = 2'b00;
        bus.acc_clr  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // AND mode, consecutive beats
        do_reset();
        bus.out_ready = 1'b1;
        send(8'h0F, 2'b00, 1'b0);
        send(8'hF0, 2'b00, 1'b0);
        send(8'hFF, 2'b00, 1'b0);
        check("and_count", bus.count, 16'd3);
        repeat (4) step();
        check("and_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("and_r0", got_q[0], 8'h00);
            check("and_r1", got_q[1], 8'h00);
            check("and_r2", got_q[2], 8'hFF);
            check("and_latency", lat_q[0], DEPTH);
        end

        // XOR, then XNOR on the third beat
        do_reset();
        send(8'h0F, 2'b10, 1'b0);
        send(8'hF0, 2'b10, 1'b0);
        send(8'hFF, 2'b10, 1'b0);
        repeat (4) step();
        do_reset();
        send(8'h0F, 2'b10, 1'b0);
        send(8'hF0, 2'b10, 1'b0);
        send(8'hFF, 2'b11, 1'b0);
        repeat (4) step();
        check("xnor_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("xnor_r0", got_q[0], 8'h0F);
            check("xnor_r1", got_q[1], 8'hFF);
            check("xnor_r2", got_q[2], 8'hFF);
        end

        // Backpressure: capacity of DEPTH, then ordered drain
        do_reset();
        bus.out_ready = 1'b0;
        send(8'h0F, 2'b10, 1'b0);
        send(8'hF0, 2'b10, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.mode     = 2'b10;
        check("bp_full", bus.in_ready, 1'b0);
        step();
        step();
        check("bp_held", bus.in_ready, 1'b0);
        check("bp_count", bus.count, 16'd2);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("bp_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("bp_r0", got_q[0], 8'h0F);
            check("bp_r1", got_q[1], 8'hFF);
            check("bp_r2", got_q[2], 8'h00);
        end

        // Clear together with a beat
        do_reset();
        send(8'h0F, 2'b10, 1'b0);
        send(8'hF0, 2'b10, 1'b0);
        send(8'hFF, 2'b10, 1'b1);
        check("clr_count", bus.count, 16'd1);
        send(8'h00, 2'b10, 1'b0);
        repeat (4) step();
        check("clr_n", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("clr_r2", got_q[2], 8'hFF);
            check("clr_r3", got_q[3], 8'hFF);
        end

        // Randomized traffic with backpressure and occasional clears
        for (int i = 0; i < 2000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 3) != 0);
            bus.in_data   = WIDTH'($urandom);
            bus.mode      = 2'($urandom);
            bus.acc_clr   = 1'($urandom_range(0, 15) == 0);
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) step();

        // Counter saturation under a full-rate stream
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 65538; i++) begin
            bus.in_data = WIDTH'($urandom);
            bus.mode    = 2'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        check("sat_count", bus.count, 16'hFFFF);
        repeat (DEPTH + 2) step();
        check("sat_hold", bus.count, 16'hFFFF);

        // Reset during a stall discards in-flight results
        bus.out_ready = 1'b0;
        send(8'h5A, 2'b01, 1'b0);
        send(8'hA5, 2'b01, 1'b0);
        step();
        check("stall_pre_valid", bus.out_valid, 1'b1);
        do_reset();
        bus.out_ready = 1'b1;
        repeat (4) step();
        check("stall_no_stale", got_q.size(), 0);
        check("stall_post_valid", bus.out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
